// File: rtl/keyed_lut_mux.sv
// keyed_lut_mux: selects the data of the {key,data} pair whose key equals `key`; highest index wins, zero on miss.
// Latency: out/hit combinational; out_q/hit_q (and dup_err when KEYED_LUT_MUX_DUP_CHK_EN is defined) update one cycle after an en=1 edge.
// Backpressure: none; en=0 holds the registered copies.
module keyed_lut_mux #(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [KEY_LEN-1:0]                   key,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
  input  logic                                 en,
  output logic [DATA_LEN-1:0]                  out,
  output logic                                 hit,
  output logic [DATA_LEN-1:0]                  out_q,
  output logic                                 hit_q
`ifdef KEYED_LUT_MUX_DUP_CHK_EN
  ,
  output logic                                 dup_err
`endif
);

  localparam int PAIR_LEN = KEY_LEN + DATA_LEN;

  logic [KEY_LEN-1:0]  pair_key [NR_KEY];
  logic [DATA_LEN-1:0] pair_dat [NR_KEY];
  logic [NR_KEY-1:0]   match;

  for (genvar g = 0; g < NR_KEY; g++) begin : g_pair
    assign pair_key[g] = lut[g*PAIR_LEN+DATA_LEN +: KEY_LEN];
    assign pair_dat[g] = lut[g*PAIR_LEN +: DATA_LEN];
    assign match[g]    = (pair_key[g] == key);
  end

  // Ascending scan so the last (highest-index) match overrides earlier ones.
  always_comb begin
    out = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (match[i]) begin
        out = pair_dat[i];
      end
    end
  end

  assign hit = |match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      hit_q <= 1'b0;
    end else if (en) begin
      out_q <= out;
      hit_q <= hit;
    end
  end

`ifdef KEYED_LUT_MUX_DUP_CHK_EN
  logic multi_hit;
  logic seen;

  always_comb begin
    multi_hit = 1'b0;
    seen      = 1'b0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (match[i]) begin
        multi_hit = multi_hit | seen;
        seen      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dup_err <= 1'b0;
    end else if (en && multi_hit) begin
      dup_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_keyed_lut_mux.sv
// Scoreboard bench for keyed_lut_mux (NR_KEY=5, KEY_LEN=3, DATA_LEN=32): directed tables then random traffic.
module tb_keyed_lut_mux;
  localparam int NR = 5;
  localparam int KL = 3;
  localparam int DL = 32;
  localparam int PL = KL + DL;
  localparam int LW = NR * PL;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [KL-1:0] key;
  logic [LW-1:0] lut;
  logic [DL-1:0] out;
  logic          hit;
  logic [DL-1:0] out_q;
  logic          hit_q;
`ifdef KEYED_LUT_MUX_DUP_CHK_EN
  logic          dup_err;
`endif

  always #5 clk = ~clk;

  keyed_lut_mux #(.NR_KEY(NR), .KEY_LEN(KL), .DATA_LEN(DL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .key   (key),
    .lut   (lut),
    .en    (en),
    .out   (out),
    .hit   (hit),
    .out_q (out_q),
`ifdef KEYED_LUT_MUX_DUP_CHK_EN
    .hit_q (hit_q),
    .dup_err (dup_err)
`else
    .hit_q (hit_q)
`endif
  );

  // Pair table held as plain arrays; the bus is packed from these.
  logic [KL-1:0] pk [NR];
  logic [DL-1:0] pd [NR];

  typedef struct packed {
    logic [DL-1:0] out;
    logic          hit;
    logic [DL-1:0] out_q;
    logic          hit_q;
    logic          dup;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [DL-1:0] m_out_q;
  logic          m_hit_q;
  logic          m_dup;

  task automatic set_pair(input int i, input logic [KL-1:0] k, input logic [DL-1:0] d);
    pk[i] = k;
    pd[i] = d;
  endtask

  // Drive one cycle at the falling edge and push two expectations:
  // one right after the drive (before the next rising edge) and one after that edge.
  task automatic drive(input logic r, input logic e, input logic [KL-1:0] k);
    logic [DL-1:0] d;
    logic          h;
    int            cnt;
    exp_t          x;
    @(negedge clk);
    rst_n = r;
    en    = e;
    key   = k;
    for (int i = 0; i < NR; i++) lut[i*PL +: PL] = {pk[i], pd[i]};
    d   = '0;
    h   = 1'b0;
    cnt = 0;
    for (int i = NR - 1; i >= 0; i--) begin
      if (pk[i] == k) begin
        cnt++;
        if (!h) begin
          h = 1'b1;
          d = pd[i];
        end
      end
    end
    if (!r) begin
      m_out_q = '0;
      m_hit_q = 1'b0;
      m_dup   = 1'b0;
    end
    x = '{out: d, hit: h, out_q: m_out_q, hit_q: m_hit_q, dup: m_dup};
    exp_q.push_back(x);
    if (r && e) begin
      m_out_q = d;
      m_hit_q = h;
      if (cnt >= 2) m_dup = 1'b1;
    end
    x.out_q = m_out_q;
    x.hit_q = m_hit_q;
    x.dup   = m_dup;
    exp_q.push_back(x);
  endtask

  task automatic check(input string tag);
    exp_t x;
    logic ok;
    if (exp_q.size() == 0) return;
    x  = exp_q.pop_front();
    ok = (out === x.out) && (hit === x.hit) && (out_q === x.out_q) && (hit_q === x.hit_q);
`ifdef KEYED_LUT_MUX_DUP_CHK_EN
    ok = ok && (dup_err === x.dup);
`endif
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s t=%0t key=%0d got out=%h hit=%b out_q=%h hit_q=%b want out=%h hit=%b out_q=%h hit_q=%b dup=%b",
               tag, $time, key, out, hit, out_q, hit_q, x.out, x.hit, x.out_q, x.hit_q, x.dup);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2 check("pre_edge");
      @(posedge clk);
      #1 check("post_edge");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    key     = '0;
    lut     = '0;
    m_out_q = '0;
    m_hit_q = 1'b0;
    m_dup   = 1'b0;

    // Extension-select table
    set_pair(0, 3'd0, 32'hFFFF_FF80);
    set_pair(1, 3'd1, 32'hFFFF_8000);
    set_pair(2, 3'd2, 32'h1234_5678);
    set_pair(3, 3'd4, 32'h0000_0080);
    set_pair(4, 3'd5, 32'h0000_8000);
    drive(1'b0, 1'b0, 3'd0);
    drive(1'b0, 1'b1, 3'd2);
    drive(1'b1, 1'b0, 3'd0);
    drive(1'b1, 1'b0, 3'd5);
    drive(1'b1, 1'b0, 3'd3);

    // Register path, hold, then async reset and release
    drive(1'b1, 1'b1, 3'd2);
    repeat (3) drive(1'b1, 1'b0, 3'd3);
    drive(1'b0, 1'b0, 3'd3);
    drive(1'b1, 1'b1, 3'd4);
    drive(1'b1, 1'b0, 3'd4);

    // Byte-lane table; pair 4 never selected by the sweep
    set_pair(3, 3'd0, 32'hAA);
    set_pair(2, 3'd1, 32'hBB);
    set_pair(1, 3'd2, 32'hCC);
    set_pair(0, 3'd3, 32'hDD);
    set_pair(4, 3'd7, 32'hEE);
    for (int k = 0; k < 4; k++) drive(1'b1, 1'b1, 3'(k));

    // Duplicate keys: index 1 must win, sticky flag until reset
    set_pair(0, 3'd1, 32'h22);
    set_pair(1, 3'd1, 32'h11);
    set_pair(2, 3'd6, 32'h33);
    set_pair(3, 3'd7, 32'h44);
    set_pair(4, 3'd5, 32'h55);
    drive(1'b1, 1'b1, 3'd1);
    drive(1'b1, 1'b1, 3'd0);
    drive(1'b1, 1'b0, 3'd2);
    drive(1'b0, 1'b0, 3'd1);
    drive(1'b1, 1'b0, 3'd0);
    drive(1'b1, 1'b1, 3'd6);

    // Random traffic with occasional table rewrites and resets
    for (int n = 0; n < 400; n++) begin
      if (n % 8 == 0) begin
        for (int i = 0; i < NR; i++) set_pair(i, 3'($urandom_range(0, 7)), $urandom);
      end
      drive(($urandom_range(0, 19) != 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end

    repeat (2) @(negedge clk);
    #4;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keyed_lut_mux.md
Name: keyed_lut_mux

Overview:
- Generic key-matched multiplexer: compares input `key` against NR_KEY {key, data} pairs packed into the flat `lut` bus, and outputs the data of the matching pair.
- Outputs 0 when no pair matches.
- Used throughout the datapath for opcode/offset-driven selection, e.g. memory-op sign/zero-extension and byte-lane select.
- Provides a combinational result plus a registered copy with a hit flag, for pipelined consumers.

Parameters:
- NR_KEY, 2, number of {key, data} pairs (≥1).
- KEY_LEN, 1, key width in bits (≥1).
- DATA_LEN, 1, data width in bits (≥1).

Ports:
- clk  input  1  clock; all registers rise-edge.
- rst_n  input  1  asynchronous active-low reset.
- key  input  KEY_LEN  selector value.
- lut  input  NR_KEY*(KEY_LEN+DATA_LEN)  packed pair table.
- en  input  1  capture enable for registered outputs.
- out  output  DATA_LEN  combinational selected data.
- hit  output  1  combinational: some pair key equals `key`.
- out_q  output  DATA_LEN  registered `out`.
- hit_q  output  1  registered `hit`.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Packing:
  - PAIR_LEN = KEY_LEN+DATA_LEN.
  - Pair i occupies lut[(i+1)*PAIR_LEN-1 : i*PAIR_LEN].
  - Within a pair, the key is in the upper KEY_LEN bits and the data in the lower DATA_LEN bits.
  - So in a concatenation {k_{N-1}, d_{N-1}, …, k_0, d_0}, the first-written pair is index N-1.
- Match: pair i matches when key == k_i (full-width, exact, no wildcards).
- out (combinational):
  - On one match, equals d_i.
  - On no match, all zeros.
  - On multiple matches, the highest-index matching pair wins (first-written in the concatenation).
- hit (combinational): OR of all pair matches.
- out and hit are purely combinational from key and lut, with zero latency and no dependence on clk or rst_n.
- Registers:
  - On posedge clk with en=1: out_q<=out, hit_q<=hit.
  - With en=0: out_q and hit_q hold their values.
  - Latency of out_q and hit_q is 1 cycle.
- Reset:
  - rst_n low immediately (asynchronously) forces out_q=0 and hit_q=0.
  - Reset has priority over en.
  - Reset asserted mid-operation discards any pending capture.
  - First capture occurs on the first posedge after rst_n deasserts.
- X on key: no requirement beyond simulation propagation.
- Runtime changes to lut are legal; they take effect combinationally.

Optional Feature:
- Macro: KEYED_LUT_MUX_DUP_CHK_EN.
- Defined:
  - Adds output port dup_err (1 bit).
  - dup_err is a sticky register: set on posedge clk when en=1 and two or more pairs match the current key simultaneously.
  - Cleared only by rst_n low (async, to 0).
  - out and out_q selection is unchanged (highest index still wins).
- Undefined: no dup_err port and no duplicate-detection logic.

Test Plan:
- Ext select, NR_KEY=5, KEY_LEN=3, DATA_LEN=32; pairs {0→FFFFFF80, 1→FFFF8000, 2→12345678, 4→00000080, 5→00008000}:
  - key=0 -> out=FFFFFF80, hit=1.
  - key=5 -> out=00008000, hit=1.
  - key=3 -> out=0, hit=0.
- Byte-lane table, NR_KEY=4, KEY_LEN=2, DATA_LEN=8, lut={2'b00,8'hAA,2'b01,8'hBB,2'b10,8'hCC,2'b11,8'hDD}:
  - Sweep key 0..3 -> out=AA, BB, CC, DD.
- Duplicate keys, NR_KEY=2, lut={2'b01,8'h11,2'b01,8'h22}, key=1:
  - -> out=11 (index 1 wins).
  - With KEYED_LUT_MUX_DUP_CHK_EN defined: dup_err=1 after next enabled edge, and stays 1 after key changes, until rst_n pulses.
- Register path, key=2 in the ext table:
  - en=1 edge -> out_q=12345678, hit_q=1.
  - Change key to 3 with en=0 -> out_q holds 12345678 and hit_q holds 1 for 3 cycles, while out=0 and hit=0 immediately.
- Async reset:
  - With out_q=12345678, drive rst_n low between edges -> out_q=0 and hit_q=0 immediately, without a clock edge.
  - Release rst_n with en=1, key=4 -> next edge out_q=00000080.
